trng_postproc: RTL and testbench
================================

// Module: trng_postproc
// PURPOSE
//   Consumes the raw sampled bit from the XOR-tree sampling flop, one bit per enabled cycle.
//   Applies a von Neumann debiaser and a repetition-count health test, then packs the
//   debiased bits into WIDTH-bit words.
//   Words are presented to the downstream consumer over a valid/ready handshake.
//   Sits between the sampling flop and the random-word consumer, in the same clock domain.
// PARAMETERS
//   WIDTH      32  output word width; must be >= 2
//   REP_LIMIT  32  count of consecutive identical raw bits that declares failure; >= 2
// PORTS
//   d_clk        in   1      system clock; all state updates on its rising edge
//   d_rst        in   1      synchronous, active-high reset
//   raw_bit      in   1      sampled raw entropy bit
//   raw_en       in   1      raw_bit is valid this cycle; cycles with raw_en=0 are ignored
//   word_out     out  WIDTH  packed random word
//   word_valid   out  1      word_out holds an undelivered word
//   word_ready   in   1      consumer accepts word_out when word_valid & word_ready
//   health_fail  out  1      sticky repetition-count failure flag
//   clr_fail     in   1      clears health_fail and restarts the datapath
// BEHAVIOUR
//   Reset (d_rst=1 at an edge) overrides every other input, including clr_fail. It clears:
//     word_out, word_valid, health_fail, accumulator, bit count, pair state and run counter.
//     The previous-bit register is marked empty.
//   Pair FSM, advancing only on raw_en=1:
//     NEED_FIRST: latch raw_bit as a, go to NEED_SECOND.
//     NEED_SECOND: compare raw_bit b with a. If a!=b, emit debiased bit a; if a==b, emit nothing.
//       Return to NEED_FIRST in both cases.
//     Pairs may span raw_en=0 gaps of any length.
//   Accumulator and bit count:
//     Accumulator: acc <= {acc[WIDTH-2:0], bit}, so the first emitted bit ends up at the MSB.
//     Bit count: cnt, $clog2(WIDTH+1) bits.
//   Word transfer:
//     When cnt==WIDTH and the output slot is free, acc moves to word_out at that edge.
//     The slot is free when word_valid=0, or word_valid=1 & word_ready=1 in the same cycle.
//     At that edge word_valid goes to 1 and cnt goes to 0.
//     A bit emitted on the same edge starts the new word (cnt goes to 1).
//   Latency: the edge that accepts the WIDTH-th bit sets cnt=WIDTH. word_valid rises one edge
//     after that, provided the slot is free.
//   Backpressure: while cnt==WIDTH and the slot is busy, acc holds and newly emitted bits are
//     dropped. The pair FSM and the health test keep running.
//   Handshake:
//     word_out stays stable while word_valid=1 & word_ready=0.
//     word_valid falls after a handshake unless a new word is loaded on the same edge.
//   Health test (on raw bits with raw_en=1, independent of pairing):
//     Run counter saturates at REP_LIMIT. If raw_bit equals the previous bit, run++;
//     otherwise run=1 (the first bit after reset or clear gives run=1).
//     The edge at which run reaches REP_LIMIT sets health_fail.
//   While health_fail=1:
//     word_valid is forced to 0 and word_out is cleared.
//     acc, cnt and the pair FSM are cleared; no words are produced.
//     The run counter freezes.
//   clr_fail=1 at an edge clears health_fail, the run counter and the previous-bit register.
//     It takes priority over a failure detected on the same edge.
//     raw_bit in that cycle is discarded.
// TESTING (WIDTH=8, REP_LIMIT=8 unless noted)
//   1. Reset, then raw_en=1 with raw 1,0,0,1 repeated for 16 bits
//      -> word_out=8'hAA; word_valid=1 one edge after the edge where cnt reaches 8.
//   2. Raw 1,1,0,0 repeated for 200 cycles -> word_valid stays 0 and health_fail stays 0.
//   3. word_ready=0 while three words of entropy arrive
//      -> word_out holds word 1 stable; acc holds word 2; later bits are dropped.
//      Then word_ready=1 for one cycle -> word 2 appears on the next edge.
//   4. Eight consecutive raw 1s with raw_en=1 -> health_fail=1 after the 8th bit's edge;
//      word_valid=0. Then a clr_fail pulse followed by the pattern of test 1 -> 8'hAA again.
//   5. Toggle raw_en every other cycle with the test 1 data
//      -> the same 8'hAA word; bits presented with raw_en=0 have no effect.
//   6. Assert d_rst after 10 raw bits, with clr_fail=1 in the same cycle
//      -> all outputs are 0 on the next edge; a fresh test 1 sequence yields 8'hAA.

Source files
------------

// File: rtl/trng_postproc_if.sv
// rtl/trng_postproc_if.sv - raw-bit input, word stream and health signals of the TRNG post-processor
interface trng_postproc_if #(
   parameter int WIDTH = 32
);
   logic             raw_bit;
   logic             raw_en;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;
   logic             health_fail;
   logic             clr_fail;

   modport master (
      input  raw_bit, raw_en, word_ready, clr_fail,
      output word_out, word_valid, health_fail
   );

   modport slave (
      output raw_bit, raw_en, word_ready, clr_fail,
      input  word_out, word_valid, health_fail
   );
endinterface

// File: rtl/trng_postproc.sv
// rtl/trng_postproc.sv - von Neumann debiaser, repetition-count health test and word packer
module trng_postproc #(
   parameter int WIDTH     = 32,
   parameter int REP_LIMIT = 32
) (
   input  logic          d_clk,
   input  logic          d_rst,
   trng_postproc_if.master io
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [RW-1:0] RUN_MAX  = RW'(REP_LIMIT);

   typedef enum logic {NEED_FIRST, NEED_SECOND} pair_e;

   pair_e            pair_q, pair_d;
   logic             a_q, a_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             fail_q, fail_d;
   logic [RW-1:0]    run_q, run_d;
   logic             prev_q, prev_d;
   logic             prev_vld_q, prev_vld_d;

   logic             emit;
   logic             slot_free;

   always_comb begin
      pair_d     = pair_q;
      a_d        = a_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      valid_d    = valid_q;
      fail_d     = fail_q;
      run_d      = run_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      emit       = 1'b0;
      slot_free  = !valid_q || io.word_ready;

      if (io.clr_fail) begin
         // Restart: the raw bit of this cycle is discarded, a pending handshake still completes.
         fail_d     = 1'b0;
         run_d      = '0;
         prev_d     = 1'b0;
         prev_vld_d = 1'b0;
         pair_d     = NEED_FIRST;
         acc_d      = '0;
         cnt_d      = '0;
         if (valid_q && io.word_ready) begin
            valid_d = 1'b0;
         end
      end else if (!fail_q) begin
         if (io.raw_en) begin
            prev_d     = io.raw_bit;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (io.raw_bit == prev_q)) begin
               run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
            end else begin
               run_d = RW'(1);
            end

            if (pair_q == NEED_FIRST) begin
               a_d    = io.raw_bit;
               pair_d = NEED_SECOND;
            end else begin
               emit   = (io.raw_bit != a_q);
               pair_d = NEED_FIRST;
            end
         end

         if ((cnt_q == CNT_FULL) && slot_free) begin
            word_d  = acc_q;
            valid_d = 1'b1;
            cnt_d   = emit ? CW'(1) : '0;
            if (emit) begin
               acc_d = {acc_q[WIDTH-2:0], a_q};
            end
         end else begin
            if (valid_q && io.word_ready) begin
               valid_d = 1'b0;
            end
            // A full accumulator waiting on a busy slot drops newly debiased bits.
            if (emit && (cnt_q != CNT_FULL)) begin
               acc_d = {acc_q[WIDTH-2:0], a_q};
               cnt_d = cnt_q + CW'(1);
            end
         end

         if (run_d == RUN_MAX) begin
            fail_d  = 1'b1;
            valid_d = 1'b0;
            word_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
            pair_d  = NEED_FIRST;
         end
      end
   end

   always_ff @(posedge d_clk) begin
      if (d_rst) begin
         pair_q     <= NEED_FIRST;
         a_q        <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         fail_q     <= 1'b0;
         run_q      <= '0;
         prev_q     <= 1'b0;
         prev_vld_q <= 1'b0;
      end else begin
         pair_q     <= pair_d;
         a_q        <= a_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         fail_q     <= fail_d;
         run_q      <= run_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
      end
   end

   assign io.word_out    = word_q;
   assign io.word_valid  = valid_q;
   assign io.health_fail = fail_q;
endmodule

// File: tb/tb_trng_postproc.sv
// tb/tb_trng_postproc.sv - randomized and directed bench against a queue-based reference model
module tb_trng_postproc;
   localparam int W = 8;
   localparam int L = 8;

   logic d_clk = 1'b0;
   logic d_rst = 1'b1;

   trng_postproc_if #(.WIDTH(W)) io ();

   trng_postproc #(.WIDTH(W), .REP_LIMIT(L)) dut (
      .d_clk (d_clk),
      .d_rst (d_rst),
      .io    (io.master)
   );

   always #5 d_clk = ~d_clk;

   int checks   = 0;
   int failures = 0;

   int          m_pair;
   bit          m_accq[$];
   int          m_run;
   int          m_prev;
   bit          m_fail;
   bit          m_valid;
   logic [W-1:0] m_word;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_step(bit rst, bit clr, bit raw, bit en, bit ready);
      bit have_bit = 1'b0;
      bit new_bit  = 1'b0;
      bit free;
      if (rst) begin
         m_pair = -1; m_accq.delete(); m_run = 0; m_prev = -1;
         m_fail = 0; m_valid = 0; m_word = '0;
         return;
      end
      if (clr) begin
         m_fail = 0; m_run = 0; m_prev = -1; m_pair = -1; m_accq.delete();
         if (m_valid && ready) m_valid = 0;
         return;
      end
      if (m_fail) return;
      free = !m_valid || ready;
      if (en) begin
         if (m_prev == int'(raw)) m_run = (m_run < L) ? m_run + 1 : L;
         else m_run = 1;
         m_prev = int'(raw);
         if (m_pair < 0) m_pair = int'(raw);
         else begin
            if (m_pair != int'(raw)) begin
               have_bit = 1'b1;
               new_bit  = m_pair[0];
            end
            m_pair = -1;
         end
      end
      if (m_accq.size() == W && free) begin
         m_word = '0;
         foreach (m_accq[i]) m_word = {m_word[W-2:0], m_accq[i]};
         m_valid = 1;
         m_accq.delete();
         if (have_bit) m_accq.push_back(new_bit);
      end else begin
         if (m_valid && ready) m_valid = 0;
         if (have_bit && m_accq.size() < W) m_accq.push_back(new_bit);
      end
      if (m_run == L) begin
         m_fail = 1; m_valid = 0; m_word = '0; m_accq.delete(); m_pair = -1;
      end
   endfunction

   task automatic cycle(input bit raw, input bit en, input bit ready, input bit clr, input bit rst);
      @(negedge d_clk);
      d_rst         = rst;
      io.raw_bit    = raw;
      io.raw_en     = en;
      io.word_ready = ready;
      io.clr_fail   = clr;
      model_step(rst, clr, raw, en, ready);
      @(posedge d_clk);
      #1;
      check("word_valid", 32'(io.word_valid), 32'(m_valid));
      check("word_out", 32'(io.word_out), 32'(m_word));
      check("health_fail", 32'(io.health_fail), 32'(m_fail));
   endtask

   task automatic feed16(input bit [3:0] pat, input bit ready);
      for (int i = 0; i < 16; i++) cycle(pat[3 - (i % 4)], 1'b1, ready, 1'b0, 1'b0);
   endtask

   task automatic expect_word(input string tag, input logic [W-1:0] w);
      check({tag, "_valid"}, 32'(io.word_valid), 32'd1);
      check({tag, "_word"}, 32'(io.word_out), 32'(w));
   endtask

   initial begin
      io.raw_bit = 0; io.raw_en = 0; io.word_ready = 0; io.clr_fail = 0;

      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_valid", 32'(io.word_valid), 32'd0);
      check("reset_word", 32'(io.word_out), 32'd0);
      check("reset_fail", 32'(io.health_fail), 32'd0);

      // Basic packing and one-edge load latency
      feed16(4'b1001, 1'b0);
      check("t1_latency", 32'(io.word_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_word("t1", 8'hAA);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t1_drain", 32'(io.word_valid), 32'd0);

      // Equal pairs only: nothing emitted, no health failure
      for (int i = 0; i < 200; i++) cycle((i % 4) < 2, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2_valid", 32'(io.word_valid), 32'd0);
      check("t2_fail", 32'(io.health_fail), 32'd0);

      // Backpressure over three words
      feed16(4'b1001, 1'b0);
      feed16(4'b0110, 1'b0);
      feed16(4'b1001, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_word("t3_hold", 8'hAA);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_word("t3_second", 8'h55);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t3_third_dropped", 32'(io.word_valid), 32'd0);

      // Repetition failure and clear
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t4_before", 32'(io.health_fail), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t4_fail", 32'(io.health_fail), 32'd1);
      check("t4_valid", 32'(io.word_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t4_clear", 32'(io.health_fail), 32'd0);
      feed16(4'b1001, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_word("t4", 8'hAA);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // raw_en gaps with garbage data
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cycle((i % 4 == 0) || (i % 4 == 3), 1'b1, 1'b0, 1'b0, 1'b0);
         cycle(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_word("t5", 8'hAA);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset wins over clr_fail mid-stream
      for (int i = 0; i < 10; i++) cycle((i % 4 == 0) || (i % 4 == 3), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("t6_valid", 32'(io.word_valid), 32'd0);
      check("t6_word", 32'(io.word_out), 32'd0);
      check("t6_fail", 32'(io.health_fail), 32'd0);
      feed16(4'b1001, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_word("t6", 8'hAA);

      // Randomized traffic with long runs mixed in
      for (int i = 0; i < 4000; i++) begin
         bit r;
         r = (i % 64 < 12) ? 1'b1 : 1'($urandom);
         cycle(r, ($urandom % 4) != 0, ($urandom % 3) != 0,
               m_fail && (($urandom % 8) == 0), ($urandom % 500) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
